// File: rtl/float_to_log_conv_pkg.sv
// Shared float/log format helpers: exponent bias, field widths, log range limits
// and the elaboration-time log2 table generator.
package float_to_log_conv_pkg;

  function automatic int getExpBias(input int expBits);
    return (1 << (expBits - 1)) - 1;
  endfunction

  function automatic int getSignedExponentBits(input int expBits);
    return expBits + 1;
  endfunction

  function automatic int getFractionBits(input int fracBits);
    return fracBits;
  endfunction

  function automatic int getLogExpMax(input int m);
    return (1 << (m - 1)) - 1;
  endfunction

  function automatic int getLogExpMin(input int m);
    return -(1 << (m - 1));
  endfunction

  // log2(1 + idx/2^lBits) scaled by 2^vBits, evaluated only at elaboration time
  function automatic real log2Scaled(input int idx, input int lBits, input int vBits);
    real ratio;
    ratio = 1.0 + real'(idx) / real'(1 << lBits);
    return $ln(ratio) / $ln(2.0) * real'(1 << vBits);
  endfunction

  function automatic int log2FracLut(input int idx, input int lBits, input int vBits);
    return $rtoi(log2Scaled(idx, lBits, vBits));
  endfunction

  function automatic bit log2FracInexact(input int idx, input int lBits, input int vBits);
    return real'(log2FracLut(idx, lBits, vBits)) != log2Scaled(idx, lBits, vBits);
  endfunction

endpackage

// File: rtl/float_to_log_conv_if.sv
// Float-in / unpacked-log-out bundle; out = {sign, isInf, isZero, signedExp[M], logFrac[F]}.
interface float_to_log_conv_if #(
  parameter int EXP  = 8,
  parameter int FRAC = 23,
  parameter int M    = 5,
  parameter int F    = 4
);
  import float_to_log_conv_pkg::*;

  logic                inValid;
  logic [EXP+FRAC:0]   in;
  logic                outValid;
  logic [M+F+2:0]      out;
  logic [2:0]          logTrailingBits;

  modport master (output inValid, in, input outValid, out, logTrailingBits);
  modport slave  (input inValid, in, output outValid, out, logTrailingBits);

endinterface

// File: rtl/float_to_log_conv_lut.sv
// Constant table mapping the top L fraction bits to floor(log2(1.f) * 2^(F+2))
// plus a flag marking entries whose exact value was not an integer.
module linear_to_log_lut
  import float_to_log_conv_pkg::*;
#(
  parameter int L = 8,
  parameter int F = 4
) (
  input  logic [L-1:0] index,
  output logic [F+1:0] value,
  output logic         inexact
);

  logic [F+2:0] rom [2**L];

  for (genvar gi = 0; gi < 2**L; gi++) begin : gRom
    localparam int  ENTRY = log2FracLut(gi, L, F + 2);
    localparam bit  INEXACT = log2FracInexact(gi, L, F + 2);
    assign rom[gi] = {ENTRY[F+1:0], INEXACT};
  end

  assign {value, inexact} = rom[index];

endmodule

// File: rtl/float_to_log_conv.sv
// Float to unpacked log converter: classify, table lookup, range clamp and a
// single output register with guard/sticky bits for later rounding.
module float_to_log_conv
  import float_to_log_conv_pkg::*;
#(
  parameter int EXP                = 8,
  parameter int FRAC               = 23,
  parameter int M                  = 5,
  parameter int F                  = 4,
  parameter int LINEAR_TO_LOG_BITS = 8,
  parameter bit SATURATE_MAX       = 1'b1
) (
  input logic                clock,
  input logic                resetn,
  float_to_log_conv_if.slave io
);

  localparam int L    = LINEAR_TO_LOG_BITS;
  localparam int EW   = getSignedExponentBits(EXP);
  localparam int FW   = getFractionBits(FRAC);
  localparam int BIAS = getExpBias(EXP);

  logic                 inSign;
  logic [EXP-1:0]       inExp;
  logic [FW-1:0]        inFrac;
  logic signed [EW-1:0] unbiasedExp;
  logic                 overflow;
  logic                 underflow;
  logic [L-1:0]         lutIndex;
  logic                 lowSticky;
  logic [F+1:0]         lutValue;
  logic                 lutInexact;

  logic                 nextInf;
  logic                 nextZero;
  logic [M-1:0]         nextExp;
  logic [F-1:0]         nextFrac;
  logic [2:0]           nextTrailing;

  logic                 validReg;
  logic [M+F+2:0]       outReg;
  logic [2:0]           trailingReg;

  assign inSign      = io.in[EXP+FRAC];
  assign inExp       = io.in[EXP+FRAC-1:FRAC];
  assign inFrac      = io.in[FRAC-1:0];
  assign unbiasedExp = signed'(EW'({1'b0, inExp}) - EW'(BIAS));
  assign overflow    = int'(unbiasedExp) > getLogExpMax(M);
  assign underflow   = int'(unbiasedExp) < getLogExpMin(M);

  // Narrow fractions are zero-padded so the table index width stays fixed
  if (L < FW) begin : gIndexTrunc
    assign lutIndex  = inFrac[FW-1 -: L];
    assign lowSticky = |inFrac[FW-L-1:0];
  end else if (L == FW) begin : gIndexExact
    assign lutIndex  = inFrac;
    assign lowSticky = 1'b0;
  end else begin : gIndexPad
    assign lutIndex  = {inFrac, {(L-FW){1'b0}}};
    assign lowSticky = 1'b0;
  end

  linear_to_log_lut #(.L(L), .F(F)) lut (
    .index   (lutIndex),
    .value   (lutValue),
    .inexact (lutInexact)
  );

  always_comb begin
    nextInf      = 1'b0;
    nextZero     = 1'b0;
    nextExp      = '0;
    nextFrac     = '0;
    nextTrailing = '0;
    if (inExp == '0) begin
      nextZero = 1'b1;
    end else if (inExp == '1) begin
      nextInf = 1'b1;
    end else if (overflow) begin
      if (SATURATE_MAX) begin
        nextExp  = M'(getLogExpMax(M));
        nextFrac = '1;
      end else begin
        nextInf = 1'b1;
      end
    end else if (underflow) begin
      // Tiny values clamp to the smallest magnitude instead of collapsing to zero
      nextExp = M'(getLogExpMin(M));
    end else begin
      nextExp      = unbiasedExp[M-1:0];
      nextFrac     = lutValue[F+1:2];
      nextTrailing = {lutValue[1:0], lutInexact | lowSticky};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      validReg    <= 1'b0;
      outReg      <= {3'b001, {(M+F){1'b0}}};
      trailingReg <= 3'b000;
    end else begin
      validReg <= io.inValid;
      if (io.inValid) begin
        outReg      <= {inSign, nextInf, nextZero, nextExp, nextFrac};
        trailingReg <= nextTrailing;
      end
    end
  end

  assign io.outValid        = validReg;
  assign io.out             = outReg;
  assign io.logTrailingBits = trailingReg;

endmodule

// File: tb/tb_float_to_log_conv.sv
// Directed bench for float_to_log_conv: vector table for single conversions plus
// reset, latency and hold sequences; a second instance covers overflow-to-infinity.
module tb_float_to_log_conv;

  logic clock;
  logic resetn;
  int   total;
  int   bad;

  float_to_log_conv_if #(.EXP(8), .FRAC(23), .M(5), .F(4)) satIf ();
  float_to_log_conv_if #(.EXP(8), .FRAC(23), .M(5), .F(4)) infIf ();

  float_to_log_conv #(.SATURATE_MAX(1'b1)) dutSat (
    .clock  (clock),
    .resetn (resetn),
    .io     (satIf.slave)
  );

  float_to_log_conv #(.SATURATE_MAX(1'b0)) dutInf (
    .clock  (clock),
    .resetn (resetn),
    .io     (infIf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [11:0] expOut;
    logic [11:0] expOutNoSat;
    logic [2:0]  expTrail;
  } vector_t;

  vector_t vectors [16];

  // Drives both instances on the falling edge, then moves just past the rising edge
  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic rst);
    @(negedge clock);
    satIf.inValid = valid;
    satIf.in      = data;
    infIf.inValid = valid;
    infIf.in      = data;
    resetn        = ~rst;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    satIf.inValid = 1'b0;
    satIf.in      = '0;
    infIf.inValid = 1'b0;
    infIf.in      = '0;

    vectors[0]  = '{"one",        32'h3F800000, 12'h000, 12'h000, 3'b000};
    vectors[1]  = '{"onePointFive",32'h3FC00000, 12'h009, 12'h009, 3'b011};
    vectors[2]  = '{"minusThree", 32'hC0400000, 12'h819, 12'h819, 3'b011};
    vectors[3]  = '{"twoPow20",   32'h49800000, 12'h0FF, 12'h400, 3'b000};
    vectors[4]  = '{"posZero",    32'h00000000, 12'h200, 12'h200, 3'b000};
    vectors[5]  = '{"negZero",    32'h80000000, 12'hA00, 12'hA00, 3'b000};
    vectors[6]  = '{"posInf",     32'h7F800000, 12'h400, 12'h400, 3'b000};
    vectors[7]  = '{"nan",        32'h7FC00001, 12'h400, 12'h400, 3'b000};
    vectors[8]  = '{"negInf",     32'hFF800000, 12'hC00, 12'hC00, 3'b000};
    vectors[9]  = '{"twoPowM20",  32'h35800000, 12'h100, 12'h100, 3'b000};
    vectors[10] = '{"denormal",   32'h00000001, 12'h200, 12'h200, 3'b000};
    vectors[11] = '{"oneUlp",     32'h3F800001, 12'h000, 12'h000, 3'b001};
    vectors[12] = '{"twoPow15",   32'h47000000, 12'h0F0, 12'h0F0, 3'b000};
    vectors[13] = '{"twoPow16",   32'h47800000, 12'h0FF, 12'h400, 3'b000};
    vectors[14] = '{"twoPowM16",  32'h37800000, 12'h100, 12'h100, 3'b000};
    vectors[15] = '{"maxIndex",   32'h3FFF8000, 12'h00F, 12'h00F, 3'b111};

    // Reset with inValid asserted must still leave the zero encoding
    applyStimulus(1'b1, 32'h3FC00000, 1'b1);
    applyStimulus(1'b1, 32'h3FC00000, 1'b1);
    checkOutput("resetValid", 16'(satIf.outValid), 16'h0);
    checkOutput("resetOut",   16'(satIf.out), 16'h200);
    checkOutput("resetTrail", 16'(satIf.logTrailingBits), 16'h0);

    applyStimulus(1'b0, 32'h3F800000, 1'b0);
    checkOutput("releaseValid", 16'(satIf.outValid), 16'h0);
    checkOutput("releaseOut",   16'(satIf.out), 16'h200);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, vectors[i].data, 1'b0);
      checkOutput({vectors[i].name, "Valid"}, 16'(satIf.outValid), 16'h1);
      checkOutput({vectors[i].name, "Out"},   16'(satIf.out), 16'(vectors[i].expOut));
      checkOutput({vectors[i].name, "Trail"}, 16'(satIf.logTrailingBits), 16'(vectors[i].expTrail));
      checkOutput({vectors[i].name, "NoSat"}, 16'(infIf.out), 16'(vectors[i].expOutNoSat));
    end

    // Idle cycles after 1.5 keep its result while outValid drops
    applyStimulus(1'b1, 32'h3FC00000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'hC0400000, 1'b0);
      checkOutput("holdValid", 16'(satIf.outValid), 16'h0);
      checkOutput("holdOut",   16'(satIf.out), 16'h009);
      checkOutput("holdTrail", 16'(satIf.logTrailingBits), 16'h3);
    end

    // 0.75 then a back-to-back second input
    applyStimulus(1'b1, 32'h3F400000, 1'b0);
    checkOutput("threeQuarterOut", 16'(satIf.out), 16'h1F9);
    applyStimulus(1'b1, 32'h3FA00000, 1'b0);
    checkOutput("oneQuarterOut",   16'(satIf.out), 16'h005);
    checkOutput("oneQuarterTrail", 16'(satIf.logTrailingBits), 16'h1);

    applyStimulus(1'b1, 32'h3F800000, 1'b1);
    checkOutput("midResetValid", 16'(satIf.outValid), 16'h0);
    checkOutput("midResetOut",   16'(satIf.out), 16'h200);
    checkOutput("midResetNoSat", 16'(infIf.out), 16'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
